// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared state type, segment constants and digit decoder for the maintenance panel
package panel_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ALERT  = 2'd1,
        REQ    = 2'd2,
        WAIT   = 2'd3
    } panel_state_e;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int unsigned BCD_ITERS = 8;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 8-bit double-dabble converter, one shift-add-3 step per cycle
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);
    import panel_pkg::*;

    logic [7:0]  sh_q, sh_d;
    logic [11:0] acc_q, acc_d;
    logic [11:0] adj;
    logic [2:0]  it_q, it_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < 3; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end

        sh_d   = sh_q;
        acc_d  = acc_q;
        it_d   = it_q;
        busy_d = busy_q;
        done_d = 1'b0;

        // A new start always wins, so a changed input restarts cleanly
        if (start) begin
            sh_d   = bin;
            acc_d  = '0;
            it_d   = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            {acc_d, sh_d} = {adj[10:0], sh_q, 1'b0};
            it_d          = it_q + 3'd1;
            if (it_q == 3'(BCD_ITERS - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            acc_q  <= '0;
            it_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            acc_q  <= acc_d;
            it_q   <= it_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = acc_q;

endmodule

// File: rtl/panel_mantenimiento.sv
// rtl/panel_mantenimiento.sv - operator panel: button debounce, alert FSM and BCD display
// Optional WAIT-state timeout back to ALERT under macro PANEL_WAIT_TIMEOUT_EN.
module panel_mantenimiento #(
    parameter int unsigned DEB_CYCLES     = 4,
    parameter int unsigned BLINK_HALF     = 8,
    parameter logic [7:0]  ALERT_CODE     = 8'hFF,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] msg,
    input  logic       btn,
    output logic       M,
    output logic       alert_led,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0
);
    import panel_pkg::*;

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_HALF + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic             db_dly_q, db_dly_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             press;

    panel_state_e     state_q, state_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             led_q, led_d;
    logic             m_q, m_d;

    logic [7:0]       shown_q, shown_d;
    logic [7:0]       tgt_q, tgt_d;
    logic             busy_q, busy_d;
    logic [11:0]      dig_q, dig_d;
    logic [6:0]       hex2_q, hex2_d;
    logic [6:0]       hex1_q, hex1_d;
    logic [6:0]       hex0_q, hex0_d;

    logic             conv_start;
    logic             conv_done;
    logic [11:0]      conv_bcd;

`ifdef PANEL_WAIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (msg),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        sync1_d   = btn;
        sync2_d   = sync1_q;
        db_d      = db_q;
        deb_cnt_d = '0;
        // Counter only advances while the synced level disagrees; any agreement restarts it
        if (sync2_q != db_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
        db_dly_d = db_q;
        press    = db_q & ~db_dly_q;

        state_d     = state_q;
        m_d         = 1'b0;
        led_d       = led_q;
        blink_cnt_d = blink_cnt_q;
`ifdef PANEL_WAIT_TIMEOUT_EN
        tmo_cnt_d   = '0;
`endif
        case (state_q)
            NORMAL: begin
                led_d       = 1'b0;
                blink_cnt_d = '0;
                if (msg == ALERT_CODE) begin
                    state_d = ALERT;
                    led_d   = 1'b1;
                end
            end
            ALERT: begin
                if (press) begin
                    state_d     = REQ;
                    m_d         = 1'b1;
                    led_d       = 1'b1;
                    blink_cnt_d = '0;
                end else if (blink_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
                    led_d       = ~led_q;
                    blink_cnt_d = '0;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLK_W'(1);
                end
            end
            REQ: begin
                state_d = WAIT;
                led_d   = 1'b1;
            end
`ifdef PANEL_WAIT_TIMEOUT_EN
            WAIT: begin
                led_d = 1'b1;
                if (msg != ALERT_CODE) begin
                    state_d = NORMAL;
                    led_d   = 1'b0;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ALERT;
                    blink_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
`else
            WAIT: begin
                led_d = 1'b1;
                if (msg != ALERT_CODE) begin
                    state_d = NORMAL;
                    led_d   = 1'b0;
                end
            end
`endif
            default: state_d = NORMAL;
        endcase

        // Conversions only run in NORMAL; leaving it abandons any in flight
        conv_start = 1'b0;
        busy_d     = busy_q;
        tgt_d      = tgt_q;
        shown_d    = shown_q;
        dig_d      = dig_q;
        if (state_q != NORMAL) begin
            busy_d = 1'b0;
        end else begin
            if (busy_q && conv_done) begin
                shown_d = tgt_q;
                dig_d   = conv_bcd;
                busy_d  = 1'b0;
            end
            if (msg != ALERT_CODE && (busy_q ? (msg != tgt_q) : (msg != shown_q))) begin
                conv_start = 1'b1;
                tgt_d      = msg;
                busy_d     = 1'b1;
            end
        end

        if (state_d != NORMAL) begin
            hex2_d = SEG_DASH;
            hex1_d = SEG_DASH;
            hex0_d = SEG_DASH;
        end else begin
            hex2_d = digit_to_seg(dig_d[11:8]);
            hex1_d = digit_to_seg(dig_d[7:4]);
            hex0_d = digit_to_seg(dig_d[3:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_q        <= 1'b0;
            db_dly_q    <= 1'b0;
            deb_cnt_q   <= '0;
            state_q     <= NORMAL;
            blink_cnt_q <= '0;
            led_q       <= 1'b0;
            m_q         <= 1'b0;
            shown_q     <= '0;
            tgt_q       <= '0;
            busy_q      <= 1'b0;
            dig_q       <= '0;
            hex2_q      <= 7'b1000000;
            hex1_q      <= 7'b1000000;
            hex0_q      <= 7'b1000000;
`ifdef PANEL_WAIT_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_dly_q    <= db_dly_d;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            led_q       <= led_d;
            m_q         <= m_d;
            shown_q     <= shown_d;
            tgt_q       <= tgt_d;
            busy_q      <= busy_d;
            dig_q       <= dig_d;
            hex2_q      <= hex2_d;
            hex1_q      <= hex1_d;
            hex0_q      <= hex0_d;
`ifdef PANEL_WAIT_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign M         = m_q;
    assign alert_led = led_q;
    assign hex2      = hex2_q;
    assign hex1      = hex1_q;
    assign hex0      = hex0_q;

endmodule

// File: tb/tb_panel_mantenimiento.sv
// tb/tb_panel_mantenimiento.sv - randomized scoreboard bench for panel_mantenimiento
module tb_panel_mantenimiento;

    localparam int         DEB   = 4;
    localparam int         BLINK = 8;
    localparam int         TMO   = 16;
    localparam logic [7:0] AC    = 8'hFF;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] msg = 8'd0;
    logic       btn = 1'b0;
    logic       M, alert_led;
    logic [6:0] hex2, hex1, hex0;

    panel_mantenimiento #(
        .DEB_CYCLES     (DEB),
        .BLINK_HALF     (BLINK),
        .ALERT_CODE     (AC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .msg       (msg),
        .btn       (btn),
        .M         (M),
        .alert_led (alert_led),
        .hex2      (hex2),
        .hex1      (hex1),
        .hex0      (hex0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [20:0] val;
    } ev_t;

    ev_t  m_e[$];
    ev_t  led_e[$];
    ev_t  hex_e[$];
    logic bh[$];

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    bit mon_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Reference model state: 0 NORMAL, 1 ALERT, 2 REQ, 3 WAIT
    int          ms = 0;
    int          entry = 0;
    int          due = 0;
    logic        db = 1'b0;
    logic        rose_prev = 1'b0;
    logic        exp_led = 1'b0;
    logic [20:0] exp_hex = {3{7'b1000000}};
    logic [7:0]  shown = 8'd0;
    logic [7:0]  pend_val = 8'd0;
    bit          pend = 1'b0;
`ifdef PANEL_WAIT_TIMEOUT_EN
    int          wcnt = 0;
`endif

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [20:0] disp_of(input int v);
        return {seg(v / 100), seg((v / 10) % 10), seg(v % 10)};
    endfunction

    function automatic logic bs(input int i);
        if (i < 1) return 1'b0;
        return bh[i-1];
    endfunction

    task automatic push_ev(input int which, input int cyc, input logic [20:0] val);
        ev_t e;
        e.cyc = cyc;
        e.val = val;
        if (which == 0)      m_e.push_back(e);
        else if (which == 1) led_e.push_back(e);
        else                 hex_e.push_back(e);
    endtask

    // Predict effects of the clock edge that samples (mv, bv)
    task automatic model_step(input logic [7:0] mv, input logic bv);
        int          n;
        int          ns;
        logic        press;
        logic        dbn;
        logic        steady;
        logic        ledn;
        logic [20:0] hx;
        bh.push_back(bv);
        n     = bh.size();
        press = rose_prev;
        steady = 1'b1;
        for (int k = 3; k <= DEB + 1; k++) begin
            if (bs(n - k) != bs(n - 2)) steady = 1'b0;
        end
        dbn       = steady ? bs(n - 2) : db;
        rose_prev = dbn & ~db;
        db        = dbn;

        if (ms != 0) begin
            pend = 1'b0;
        end else begin
            if (pend && n == due) begin
                shown = pend_val;
                pend  = 1'b0;
            end
            if (mv != AC && mv != (pend ? pend_val : shown)) begin
                pend     = 1'b1;
                pend_val = mv;
                due      = n + 9;
            end
        end

        ns = ms;
        case (ms)
            0: if (mv == AC) begin ns = 1; entry = n; end
            1: if (press) ns = 2;
            2: begin
                ns = 3;
`ifdef PANEL_WAIT_TIMEOUT_EN
                wcnt = 0;
`endif
            end
            default: begin
                if (mv != AC) ns = 0;
`ifdef PANEL_WAIT_TIMEOUT_EN
                else begin
                    wcnt++;
                    if (wcnt == TMO) begin ns = 1; entry = n; end
                end
`endif
            end
        endcase

        if (ns == 2) push_ev(0, n, 21'd1);
        if (ns == 0)      ledn = 1'b0;
        else if (ns == 1) ledn = (((n - entry) / BLINK) % 2) == 0;
        else              ledn = 1'b1;
        if (ledn != exp_led) push_ev(1, n, {20'd0, ledn});
        exp_led = ledn;
        hx = (ns != 0) ? {DASH, DASH, DASH} : disp_of(int'(shown));
        if (hx != exp_hex) push_ev(2, n, hx);
        exp_hex = hx;
        ms = ns;
    endtask

    task automatic step(input logic [7:0] mv, input logic bv);
        msg = mv;
        btn = bv;
        model_step(mv, bv);
        @(negedge clk);
    endtask

    task automatic hold(input logic [7:0] mv, input logic bv, input int n);
        for (int i = 0; i < n; i++) step(mv, bv);
    endtask

    task automatic chk(input string name, input logic [20:0] got, input logic [20:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chk_ev(input string name, input ev_t e, input int cyc, input logic [20:0] got);
        tests++;
        if (e.cyc != cyc || e.val !== got) begin
            fails++;
            $display("FAIL %s: got value %h at cycle %0d, expected %h at cycle %0d",
                     name, got, cyc, e.val, e.cyc);
        end
    endtask

    task automatic chk_empty(input string name, input int sz);
        tests++;
        if (sz != 0) begin
            fails++;
            $display("FAIL %s: %0d expected events never observed, expected 0", name, sz);
        end
    endtask

    // Monitor: any observed output event consumes the next prediction for that output
    logic [20:0] last_hex = {3{7'b1000000}};
    logic        last_led = 1'b0;
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (M === 1'b1) begin
                    if (m_e.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL m_pulse: got unexpected M at cycle %0d, expected none", edge_cnt);
                    end else begin
                        e = m_e.pop_front();
                        chk_ev("m_pulse", e, edge_cnt, {20'd0, M});
                    end
                end
                if (alert_led !== last_led) begin
                    last_led = alert_led;
                    if (led_e.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL led: got unexpected change to %b at cycle %0d, expected none", alert_led, edge_cnt);
                    end else begin
                        e = led_e.pop_front();
                        chk_ev("led", e, edge_cnt, {20'd0, alert_led});
                    end
                end
                if ({hex2, hex1, hex0} !== last_hex) begin
                    last_hex = {hex2, hex1, hex0};
                    if (hex_e.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL hex: got unexpected change to %h at cycle %0d, expected none", last_hex, edge_cnt);
                    end else begin
                        e = hex_e.pop_front();
                        chk_ev("hex", e, edge_cnt, last_hex);
                    end
                end
            end
        end
    end

    initial begin
        bit got_m;
        repeat (3) @(negedge clk);
        chk("reset_hex", {hex2, hex1, hex0}, {3{7'b1000000}});
        chk("reset_m", {20'd0, M}, 21'd0);
        chk("reset_led", {20'd0, alert_led}, 21'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        hold(8'd137, 1'b0, 14);
        hold(8'd0, 1'b0, 4);
        hold(8'd200, 1'b0, 5);
        hold(8'd42, 1'b0, 14);
        hold(AC, 1'b0, 20);
        hold(AC, 1'b1, 3);
        hold(AC, 1'b0, 10);
        hold(AC, 1'b1, 10);
        hold(AC, 1'b0, 10);
        hold(AC, 1'b1, 10);
        hold(AC, 1'b0, 10);
        hold(8'd5, 1'b0, 14);
        hold(8'd254, 1'b0, 14);

        for (int r = 0; r < 25; r++) begin
            int nv;
            int np;
            nv = $urandom_range(1, 4);
            for (int v = 0; v < nv; v++) begin
                hold(8'($urandom_range(0, 254)), 1'($urandom_range(0, 1)), $urandom_range(2, 14));
            end
            np = $urandom_range(1, 5);
            for (int p = 0; p < np; p++) begin
                hold(AC, 1'b1, $urandom_range(1, 12));
                hold(AC, 1'b0, $urandom_range(1, 10));
            end
            hold(AC, 1'b0, $urandom_range(0, 20));
        end
        hold(8'd99, 1'b0, 30);
        #1;
        chk_empty("m_pending", m_e.size());
        chk_empty("led_pending", led_e.size());
        chk_empty("hex_pending", hex_e.size());

        // Reset asserted while REQ drives M must drop outputs at once
        mon_en = 1'b0;
        rst = 1'b1;
        msg = AC;
        btn = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        btn   = 1'b1;
        got_m = 1'b0;
        for (int i = 0; i < 30 && !got_m; i++) begin
            @(negedge clk);
            if (M === 1'b1) got_m = 1'b1;
        end
        tests++;
        if (!got_m) begin
            fails++;
            $display("FAIL req_setup: got no M within 30 cycles, expected a pulse");
        end else begin
            rst = 1'b1;
            #1;
            chk("rst_mid_req_m", {20'd0, M}, 21'd0);
            chk("rst_mid_req_led", {20'd0, alert_led}, 21'd0);
            chk("rst_mid_req_hex", {hex2, hex1, hex0}, {3{7'b1000000}});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/panel_mantenimiento.md
Name: panel_mantenimiento

Overview:
- Operator-side counterpart of the maintenance controller: consumes its 8-bit msg stream and produces its M request input.
- Decodes msg:
  - Alert code: blinks the alert LED and shows dashes.
  - Maintenance count: converted to BCD and shown on three active-low 7-segment digits.
- Debounces the raw operator button and issues a single-cycle M request only while an alert is pending.
- Sits at board top level, between pins and the maintenance system.

Parameters:
- DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change (>=1).
- BLINK_HALF, 8, cycles per half-period of alert_led blinking (>=1).
- ALERT_CODE, 8'hFF, msg value meaning "maintenance required".
- TIMEOUT_CYCLES, 16, WAIT-state timeout length; used only with PANEL_WAIT_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- msg  input  8  message from the maintenance controller (registered at source).
- btn  input  1  raw asynchronous push-button, active high.
- M  output  1  maintenance request; exactly one clk cycle high per accepted press.
- alert_led  output  1  blinks while an alert is pending.
- hex2  output  7  hundreds digit segments {g..a}, active low.
- hex1  output  7  tens digit segments {g..a}, active low.
- hex0  output  7  units digit segments {g..a}, active low.

Behaviour:
- Reset (async, immediate):
  - State NORMAL; M=0, alert_led=0.
  - hex2/hex1/hex0 = 7'b1000000 ("000").
  - Debounce, blink and BCD engines cleared; sync flops cleared.
  - Reset mid-conversion or mid-request aborts with no M pulse.
- Button path:
  - btn passes a 2-FF synchronizer.
  - btn_db changes only after the synchronized level differs from btn_db for DEB_CYCLES consecutive cycles; any glitch restarts the count.
  - press = btn_db 0->1 edge, one cycle wide.
  - Minimum press-to-M latency is 2 + DEB_CYCLES + 1 cycles.
- FSM states: NORMAL, ALERT, REQ, WAIT.
  - NORMAL: msg==ALERT_CODE -> ALERT next cycle. Presses are ignored.
  - ALERT: alert_led toggles every BLINK_HALF cycles, starting high on entry. press -> REQ.
  - REQ: M=1 for this one cycle -> WAIT unconditionally.
  - WAIT: alert_led steady high; presses ignored. msg!=ALERT_CODE -> NORMAL.
  - alert_led=0 and the blink counter is cleared whenever in NORMAL.
  - A press in the same cycle as the ALERT entry condition is ignored; it does not carry into ALERT.
- Display:
  - In ALERT/REQ/WAIT, all digits show dash 7'b0111111.
  - In NORMAL, when msg differs from the last converted value, an 8-iteration shift-add-3 BCD conversion (double dabble) starts.
  - Digits update 9 cycles after the change is sampled.
  - If msg changes during a conversion, the conversion restarts with the new value; digits keep the old value until a conversion completes.
  - Range 0..254 is displayed. 255 never reaches the display (it is ALERT_CODE with the default parameter).
  - Segment encoding for 0-9 is the standard active-low table.

Optional Feature:
- Macro PANEL_WAIT_TIMEOUT_EN.
  - Defined: in WAIT, a counter runs while msg==ALERT_CODE. At TIMEOUT_CYCLES it returns to ALERT (blinking resumes, a new press allowed). The counter clears on WAIT entry.
  - Undefined: WAIT persists indefinitely until msg!=ALERT_CODE; no timeout logic is synthesized.

Decomposition:
- Package panel_pkg:
  - State enum typedef (NORMAL, ALERT, REQ, WAIT).
  - SEG_DASH and SEG_BLANK constants.
  - Digit-to-segment lookup function.
- Sub-module bin2bcd_seq: sequential 8-bit double-dabble converter.
  - Ports: clk, rst, start, bin[7:0], done, bcd[11:0].
  - Instantiated once; debounce and FSM stay in the top module.

Test Plan:
- Reset with msg=8'd0 held -> hex2/hex1/hex0 = 7'b1000000, M=0, alert_led=0.
- msg 0->8'd137 -> after 9 cycles hex2=7'b1111001 ("1"), hex1=7'b0110000 ("3"), hex0=7'b1111000 ("7"); no change before.
- msg=8'hFF -> next cycle digits show dashes; alert_led high for 8 cycles, low for 8, repeating.
- In ALERT, btn held high 10 cycles -> M high exactly one cycle, 7 cycles after btn rise. btn pulses of 3 cycles -> no M.
- After M, msg stays 8'hFF, second press -> no M (WAIT). Then msg=8'd5 -> NORMAL, alert_led=0, digits "005" after 9 cycles.
- PANEL_WAIT_TIMEOUT_EN defined, msg held 8'hFF 16 cycles in WAIT -> back to ALERT; a new press gives a new M pulse. rst asserted mid-REQ -> M=0 immediately.
